lsu: RTL and testbench
======================

LSU -- requirements
Module: lsu

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYC, default 256, giving the maximum cycles to wait for mem_gnt_i or mem_rvalid_i before a bus error; 0 disables the timeout.
REQ-002 clk_i  input  1  single clock; all state changes on its rising edge.
REQ-003 rst_i  input  1  reset, synchronous and active-high.
REQ-004 valid_i  input  1  execute stage presents a memory op.
REQ-005 ready_o  output  1  LSU can accept an op (high only in IDLE).
REQ-006 we_i  input  1  1 = store, 0 = load.
REQ-007 funct3_i  input  3  RISC-V width code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-008 addr_i  input  32  effective address (ALU result, `RegBus).
REQ-009 wdata_i  input  32  store data (rs2).
REQ-010 mem_req_o  output  1  bus request.
REQ-011 mem_gnt_i  input  1  bus grant.
REQ-012 mem_we_o  output  1  bus write enable.
REQ-013 mem_addr_o  output  32  word-aligned address, bits [1:0] = 00.
REQ-014 mem_be_o  output  4  byte enables.
REQ-015 mem_wdata_o  output  32  lane-shifted store data.
REQ-016 mem_rvalid_i  input  1  read data valid.
REQ-017 mem_rdata_i  input  32  read data word.
REQ-018 done_o  output  1  one-cycle completion pulse.
REQ-019 rdata_o  output  32  extended load result, valid with done_o.
REQ-020 err_o  output  1  with done_o: misaligned, illegal funct3, or timeout.
REQ-021 busy_o  output  1  pipeline stall request, high whenever state is not IDLE.

Function
REQ-022 States: IDLE, REQ, WAIT, DONE, ERR.
REQ-023 IDLE: ready_o=1; on valid_i=1 capture we_i, funct3_i, addr_i, wdata_i; go to ERR on misaligned access (H/HU with addr[0]=1; W with addr[1:0]!=00) or illegal funct3 (011, 110, 111, or store with 1xx), else go to REQ.
REQ-024 REQ: mem_req_o=1 with address, we, be, wdata stable from captured values; on mem_gnt_i=1 a store goes to DONE and a load goes to WAIT.
REQ-025 WAIT: on mem_rvalid_i=1 register the extended data into rdata_o and go to DONE; rvalid arriving in the same cycle as gnt is ignored, so rvalid counts only from the cycle after gnt.
REQ-026 DONE: done_o=1, err_o=0 for one cycle, then IDLE; ERR: done_o=1, err_o=1, rdata_o=0 for one cycle, then IDLE.
REQ-027 Best-case latency: a store accepted at cycle 0 with gnt at cycle 1 gives done_o at cycle 2; a load with rvalid at cycle 2 gives done_o at cycle 3.
REQ-028 Byte enables: B = 0001<<addr[1:0]; H = 0011<<addr[1:0]; W = 1111.
REQ-029 Store lanes: B replicates wdata[7:0] to all 4 bytes; H replicates wdata[15:0] to both halves; W passes through.
REQ-030 Load extraction: select the byte or half by addr[1:0], then sign-extend (B, H) or zero-extend (BU, HU).
REQ-031 Timeout counter: clears on entry to REQ and WAIT and increments each cycle in those states; when it reaches TIMEOUT_CYC (nonzero) go to ERR and drop mem_req_o.
REQ-032 valid_i is ignored outside IDLE; the upstream stage holds the op while busy_o=1.

Reset
REQ-033 While rst_i=1 at a clock edge: state=IDLE, counter=0, done_o=0, err_o=0, rdata_o=0, mem_req_o=0.
REQ-034 Reset in any state, including an outstanding load, aborts the op without done_o; a late mem_rvalid_i after reset is ignored in IDLE.

Structure
REQ-035 The shared core parameter file SHALL hold the funct3 width codes, state encodings and `RegBus; the block SHALL use `include only and no local redefinitions.
REQ-036 Byte-enable/store-lane generation and load extraction/extension SHALL be one combinational sub-module, lsu_align.

Verification
REQ-037 SW addr 0x104, wdata 0xDEADBEEF, gnt at cycle 1 -> mem_addr_o 0x104, be 1111, done_o at cycle 2, err_o 0.
REQ-038 SB addr 0x103, wdata 0x000000A5 -> be 1000, mem_wdata_o 0xA5A5A5A5.
REQ-039 LB then LBU at addr 0x102, rdata 0x12F03456 -> rdata_o 0xFFFFFFF0, then 0x000000F0.
REQ-040 LH addr 0x101 -> no mem_req_o; done_o and err_o high one cycle after accept.
REQ-041 LW with gnt but no rvalid, TIMEOUT_CYC=4 -> done_o and err_o after 4 WAIT cycles; rvalid arriving afterwards is ignored.
REQ-042 rst_i asserted in WAIT -> next cycle IDLE, ready_o=1, no done_o pulse.

Source files
------------

// File: rtl/lsu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : lsu_pkg
//  Description : Shared definitions for the load/store unit: register width,
//                RISC-V funct3 width codes, FSM state encoding and the
//                access-legality helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package lsu_pkg;

    // Architectural register / bus width
    localparam int REG_BUS = 32;

    // RISC-V load/store width codes (funct3)
    localparam logic [2:0] C_F3_B  = 3'b000;
    localparam logic [2:0] C_F3_H  = 3'b001;
    localparam logic [2:0] C_F3_W  = 3'b010;
    localparam logic [2:0] C_F3_BU = 3'b100;
    localparam logic [2:0] C_F3_HU = 3'b101;

    // LSU control states
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_REQ  = 3'd1,
        ST_WAIT = 3'd2,
        ST_DONE = 3'd3,
        ST_ERR  = 3'd4
    } state_t;

    // True when the op can never be issued to the bus: an undefined width code,
    // an unsigned width on a store, or an address not aligned to the width.
    function automatic logic op_is_bad(input logic       we,
                                       input logic [2:0] f3,
                                       input logic [1:0] addr_lo);
        logic bad;
        bad = 1'b0;
        case (f3)
            C_F3_B:  bad = 1'b0;
            C_F3_H:  bad = addr_lo[0];
            C_F3_W:  bad = |addr_lo;
            C_F3_BU: bad = we;
            C_F3_HU: bad = we | addr_lo[0];
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage : lsu_pkg
`default_nettype wire

// File: rtl/lsu_align.sv
`default_nettype none
// ============================================================================
//  Module      : lsu_align
//  Description : Combinational data alignment for the LSU. Builds byte
//                enables and lane-replicated store data, and extracts plus
//                sign/zero-extends the addressed byte or half of a load word.
//  Revision    : 1.0 - initial release
// ============================================================================
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]         funct3_i,
    input  logic [1:0]         addr_lo_i,
    input  logic [REG_BUS-1:0] wdata_i,
    input  logic [REG_BUS-1:0] rdata_i,
    output logic [3:0]         be_o,
    output logic [REG_BUS-1:0] wdata_o,
    output logic [REG_BUS-1:0] rdata_o
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Lane selection for loads; halves are aligned so only addr[1] matters
    assign w_byte = rdata_i[{addr_lo_i, 3'b000} +: 8];
    assign w_half = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];

    // Byte enables and store lanes: narrow data is replicated so every lane carries it
    always_comb begin
        be_o    = 4'b1111;
        wdata_o = wdata_i;
        case (funct3_i)
            C_F3_B, C_F3_BU: begin
                be_o    = 4'b0001 << addr_lo_i;
                wdata_o = {4{wdata_i[7:0]}};
            end
            C_F3_H, C_F3_HU: begin
                be_o    = 4'b0011 << addr_lo_i;
                wdata_o = {2{wdata_i[15:0]}};
            end
            default: begin
                be_o    = 4'b1111;
                wdata_o = wdata_i;
            end
        endcase
    end

    // Load result extension according to the width code
    always_comb begin
        rdata_o = rdata_i;
        case (funct3_i)
            C_F3_B:  rdata_o = {{24{w_byte[7]}}, w_byte};
            C_F3_BU: rdata_o = {24'h000000, w_byte};
            C_F3_H:  rdata_o = {{16{w_half[15]}}, w_half};
            C_F3_HU: rdata_o = {16'h0000, w_half};
            default: rdata_o = rdata_i;
        endcase
    end

endmodule : lsu_align
`default_nettype wire

// File: rtl/lsu.sv
`default_nettype none
// ============================================================================
//  Module      : lsu
//  Description : Single-outstanding load/store unit. Accepts one memory op
//                from execute, drives a req/gnt + rvalid bus, aligns data and
//                reports completion or bus error (misaligned, illegal width,
//                or grant/read-data timeout) with a one-cycle done pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module lsu
    import lsu_pkg::*;
#(
    parameter int TIMEOUT_CYC = 256
)
(
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               valid_i,
    output logic               ready_o,
    input  logic               we_i,
    input  logic [2:0]         funct3_i,
    input  logic [REG_BUS-1:0] addr_i,
    input  logic [REG_BUS-1:0] wdata_i,
    output logic               mem_req_o,
    input  logic               mem_gnt_i,
    output logic               mem_we_o,
    output logic [REG_BUS-1:0] mem_addr_o,
    output logic [3:0]         mem_be_o,
    output logic [REG_BUS-1:0] mem_wdata_o,
    input  logic               mem_rvalid_i,
    input  logic [REG_BUS-1:0] mem_rdata_i,
    output logic               done_o,
    output logic [REG_BUS-1:0] rdata_o,
    output logic               err_o,
    output logic               busy_o
);

    // Counter just wide enough to hold TIMEOUT_CYC; a zero timeout disables expiry
    localparam int               CNT_W      = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam bit               C_TO_EN    = (TIMEOUT_CYC > 0);
    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'((TIMEOUT_CYC > 0) ? (TIMEOUT_CYC - 1) : 0);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [REG_BUS-1:0] rdata_q, rdata_d;
    logic               we_q;
    logic [2:0]         funct3_q;
    logic [REG_BUS-1:0] addr_q;
    logic [REG_BUS-1:0] wdata_q;

    logic               w_capture;
    logic               w_timeout;
    logic [REG_BUS-1:0] w_load_ext;

    lsu_align u_align (
        .funct3_i  (funct3_q),
        .addr_lo_i (addr_q[1:0]),
        .wdata_i   (wdata_q),
        .rdata_i   (mem_rdata_i),
        .be_o      (mem_be_o),
        .wdata_o   (mem_wdata_o),
        .rdata_o   (w_load_ext)
    );

    // Bus fields come straight from the captured op so they stay stable during REQ
    assign mem_we_o   = we_q;
    assign mem_addr_o = {addr_q[REG_BUS-1:2], 2'b00};
    assign rdata_o    = rdata_q;
    assign busy_o     = (state_q != ST_IDLE);

    // The last count value is reached after TIMEOUT_CYC cycles in REQ or WAIT
    assign w_timeout  = C_TO_EN && (cnt_q == C_CNT_LAST);

    // Next-state, counter and handshake outputs
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rdata_d   = rdata_q;
        w_capture = 1'b0;
        ready_o   = 1'b0;
        mem_req_o = 1'b0;
        done_o    = 1'b0;
        err_o     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                ready_o = 1'b1;
                if (valid_i) begin
                    w_capture = 1'b1;
                    rdata_d   = '0;
                    if (op_is_bad(we_i, funct3_i, addr_i[1:0])) begin
                        state_d = ST_ERR;
                    end else begin
                        state_d = ST_REQ;
                        cnt_d   = '0;
                    end
                end
            end
            ST_REQ: begin
                mem_req_o = 1'b1;
                if (mem_gnt_i) begin
                    state_d = we_q ? ST_DONE : ST_WAIT;
                    cnt_d   = '0;
                end else if (w_timeout) begin
                    state_d = ST_ERR;
                    rdata_d = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_WAIT: begin
                // rvalid is only looked at here, so one coincident with gnt is dropped
                if (mem_rvalid_i) begin
                    state_d = ST_DONE;
                    rdata_d = w_load_ext;
                end else if (w_timeout) begin
                    state_d = ST_ERR;
                    rdata_d = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DONE: begin
                done_o  = 1'b1;
                state_d = ST_IDLE;
            end
            ST_ERR: begin
                done_o  = 1'b1;
                err_o   = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, counter, result and captured-op registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            rdata_q  <= '0;
            we_q     <= 1'b0;
            funct3_q <= 3'b000;
            addr_q   <= '0;
            wdata_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            if (w_capture) begin
                we_q     <= we_i;
                funct3_q <= funct3_i;
                addr_q   <= addr_i;
                wdata_q  <= wdata_i;
            end
        end
    end

endmodule : lsu
`default_nettype wire

// File: tb/tb_lsu.sv
`default_nettype none
// ============================================================================
//  Module      : tb_lsu
//  Description : Scoreboard testbench for lsu. Stimulus pushes expected bus
//                requests and completions into queues; monitors pop and
//                compare whenever the DUT presents a granted request or done.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_lsu;

    logic        clk_i        = 1'b0;
    logic        rst_i        = 1'b1;
    logic        valid_i      = 1'b0;
    logic        we_i         = 1'b0;
    logic [2:0]  funct3_i     = 3'b000;
    logic [31:0] addr_i       = 32'h0;
    logic [31:0] wdata_i      = 32'h0;
    logic        mem_gnt_i    = 1'b0;
    logic        mem_rvalid_i = 1'b0;
    logic [31:0] mem_rdata_i  = 32'h0;

    logic        ready_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_wdata_o;
    logic        done_o;
    logic [31:0] rdata_o;
    logic        err_o;
    logic        busy_o;

    lsu #(.TIMEOUT_CYC(4)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .valid_i      (valid_i),
        .ready_o      (ready_o),
        .we_i         (we_i),
        .funct3_i     (funct3_i),
        .addr_i       (addr_i),
        .wdata_i      (wdata_i),
        .mem_req_o    (mem_req_o),
        .mem_gnt_i    (mem_gnt_i),
        .mem_we_o     (mem_we_o),
        .mem_addr_o   (mem_addr_o),
        .mem_be_o     (mem_be_o),
        .mem_wdata_o  (mem_wdata_o),
        .mem_rvalid_i (mem_rvalid_i),
        .mem_rdata_i  (mem_rdata_i),
        .done_o       (done_o),
        .rdata_o      (rdata_o),
        .err_o        (err_o),
        .busy_o       (busy_o)
    );

    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    typedef struct {
        logic        err;
        logic        chk_rd;
        logic [31:0] rd;
        int          cyc;
    } resp_t;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic        chk_wd;
        logic [31:0] wd;
    } bus_t;

    resp_t rq[$];
    bus_t  bq[$];

    int   nerr      = 0;
    int   nchk      = 0;
    logic rst_prev  = 1'b0;
    logic end_req   = 1'b0;

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    // Issue one op at cycle t0, then drive gnt at t0+1+gw and rvalid gw/rw later
    task automatic run_op(input logic we, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wd,
                          input int gw, input int rw, input logic early_rv,
                          input logic [31:0] rdat,
                          input logic xerr, input logic xchk_rd, input logic [31:0] xrd,
                          input int xdone,
                          input logic xbus, input logic [3:0] xbe,
                          input logic xchk_wd, input logic [31:0] xwd);
        int    t0;
        int    g;
        int    r;
        resp_t e;
        bus_t  b;
        step();
        t0       = cyc;
        valid_i  = 1'b1;
        we_i     = we;
        funct3_i = f3;
        addr_i   = addr;
        wdata_i  = wd;
        e.err    = xerr;
        e.chk_rd = xchk_rd;
        e.rd     = xrd;
        e.cyc    = t0 + xdone;
        rq.push_back(e);
        if (xbus) begin
            b.we     = we;
            b.addr   = {addr[31:2], 2'b00};
            b.be     = xbe;
            b.chk_wd = xchk_wd;
            b.wd     = xwd;
            bq.push_back(b);
        end
        g = t0 + 1 + gw;
        r = g + 1 + rw;
        for (int k = 1; k < 10; k++) begin
            step();
            valid_i      = 1'b0;
            mem_gnt_i    = (gw >= 0) && (cyc == g);
            mem_rvalid_i = ((rw >= 0) && (cyc == r)) || (early_rv && (gw >= 0) && (cyc == g));
            if ((rw >= 0) && (cyc == r))
                mem_rdata_i = rdat;
            else if (mem_rvalid_i)
                mem_rdata_i = 32'hBAD0BAD0;
            else
                mem_rdata_i = 32'h0;
        end
        mem_gnt_i    = 1'b0;
        mem_rvalid_i = 1'b0;
        mem_rdata_i  = 32'h0;
    endtask

    // Monitor: reset state, completions, granted bus requests, and final summary
    always @(negedge clk_i) begin
        resp_t e;
        bus_t  b;
        if (rst_i && rst_prev) begin
            nchk++;
            if (ready_o !== 1'b1 || busy_o !== 1'b0 || done_o !== 1'b0 || err_o !== 1'b0 ||
                rdata_o !== 32'h0 || mem_req_o !== 1'b0) begin
                nerr++;
                $display("FAIL reset_state: got ready=%b busy=%b done=%b err=%b rdata=%h req=%b, want 1 0 0 0 00000000 0",
                         ready_o, busy_o, done_o, err_o, rdata_o, mem_req_o);
            end
        end
        if (!rst_i && rst_prev) begin
            nchk++;
            if (ready_o !== 1'b1 || busy_o !== 1'b0 || done_o !== 1'b0) begin
                nerr++;
                $display("FAIL after_reset_idle: got ready=%b busy=%b done=%b, want 1 0 0",
                         ready_o, busy_o, done_o);
            end
        end
        if (!rst_i && done_o) begin
            nchk++;
            if (rq.size() == 0) begin
                nerr++;
                $display("FAIL unexpected_done: got done=1 err=%b at cycle %0d, want no done", err_o, cyc);
            end else begin
                e = rq.pop_front();
                if (err_o !== e.err || (e.chk_rd && rdata_o !== e.rd) || cyc != e.cyc) begin
                    nerr++;
                    $display("FAIL done_resp: got err=%b rdata=%h cycle=%0d, want err=%b rdata=%h cycle=%0d",
                             err_o, rdata_o, cyc, e.err, e.rd, e.cyc);
                end
            end
        end
        if (!rst_i && mem_req_o) begin
            if (bq.size() == 0) begin
                nchk++;
                nerr++;
                $display("FAIL unexpected_req: got mem_req=1 addr=%h at cycle %0d, want no request", mem_addr_o, cyc);
            end else if (mem_gnt_i) begin
                b = bq.pop_front();
                nchk++;
                if (mem_we_o !== b.we || mem_addr_o !== b.addr || mem_be_o !== b.be ||
                    (b.chk_wd && mem_wdata_o !== b.wd)) begin
                    nerr++;
                    $display("FAIL bus_req: got we=%b addr=%h be=%b wdata=%h, want we=%b addr=%h be=%b wdata=%h",
                             mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o, b.we, b.addr, b.be, b.wd);
                end
            end
        end
        if (end_req) begin
            nchk++;
            if (rq.size() != 0 || bq.size() != 0) begin
                nerr++;
                $display("FAIL leftover: got %0d responses and %0d requests outstanding, want 0 and 0",
                         rq.size(), bq.size());
            end
            $display("Result: errors=%0d of %0d checks", nerr, nchk);
            $finish;
        end
        rst_prev = rst_i;
    end

    // Directed stimulus
    initial begin
        bus_t b;
        rst_i = 1'b1;
        repeat (3) @(posedge clk_i);
        #1;
        rst_i = 1'b0;

        //     we  f3      addr          wdata         gw rw  erv rdat          err chk rd            done bus be       chkwd wd
        run_op(1, 3'b010, 32'h0000_0104, 32'hDEADBEEF, 0, -1, 0, 32'h0,        0,  0, 32'h0,        2,   1, 4'b1111, 1, 32'hDEADBEEF);
        run_op(1, 3'b000, 32'h0000_0103, 32'h0000_00A5, 0, -1, 0, 32'h0,       0,  0, 32'h0,        2,   1, 4'b1000, 1, 32'hA5A5A5A5);
        run_op(1, 3'b001, 32'h0000_0102, 32'h1234_BEEF, 2, -1, 0, 32'h0,       0,  0, 32'h0,        4,   1, 4'b1100, 1, 32'hBEEFBEEF);
        run_op(0, 3'b000, 32'h0000_0102, 32'h0,        0,  0, 0, 32'h12F03456, 0,  1, 32'hFFFFFFF0, 3,   1, 4'b0100, 0, 32'h0);
        run_op(0, 3'b100, 32'h0000_0102, 32'h0,        0,  0, 0, 32'h12F03456, 0,  1, 32'h000000F0, 3,   1, 4'b0100, 0, 32'h0);
        run_op(0, 3'b001, 32'h0000_0102, 32'h0,        0,  0, 0, 32'h12F03456, 0,  1, 32'h000012F0, 3,   1, 4'b1100, 0, 32'h0);
        run_op(0, 3'b001, 32'h0000_0100, 32'h0,        0,  0, 0, 32'h12349ABC, 0,  1, 32'hFFFF9ABC, 3,   1, 4'b0011, 0, 32'h0);
        run_op(0, 3'b101, 32'h0000_0100, 32'h0,        0,  0, 0, 32'h12349ABC, 0,  1, 32'h00009ABC, 3,   1, 4'b0011, 0, 32'h0);
        run_op(0, 3'b000, 32'h0000_0103, 32'h0,        0,  0, 0, 32'h80000000, 0,  1, 32'hFFFFFF80, 3,   1, 4'b1000, 0, 32'h0);
        run_op(0, 3'b010, 32'h0000_0108, 32'h0,        2,  1, 0, 32'hCAFEF00D, 0,  1, 32'hCAFEF00D, 6,   1, 4'b1111, 0, 32'h0);
        run_op(0, 3'b010, 32'h0000_010C, 32'h0,        0,  1, 1, 32'h11223344, 0,  1, 32'h11223344, 4,   1, 4'b1111, 0, 32'h0);
        run_op(0, 3'b001, 32'h0000_0101, 32'h0,       -1, -1, 0, 32'h0,        1,  1, 32'h0,        1,   0, 4'b0000, 0, 32'h0);
        run_op(0, 3'b010, 32'h0000_0102, 32'h0,       -1, -1, 0, 32'h0,        1,  1, 32'h0,        1,   0, 4'b0000, 0, 32'h0);
        run_op(0, 3'b011, 32'h0000_0100, 32'h0,       -1, -1, 0, 32'h0,        1,  1, 32'h0,        1,   0, 4'b0000, 0, 32'h0);
        run_op(1, 3'b100, 32'h0000_0100, 32'h0000_0055, -1, -1, 0, 32'h0,      1,  1, 32'h0,        1,   0, 4'b0000, 0, 32'h0);
        run_op(0, 3'b010, 32'h0000_0200, 32'h0,        0,  5, 0, 32'h77777777, 1,  1, 32'h0,        6,   1, 4'b1111, 0, 32'h0);

        // Reset while a load is outstanding in WAIT: no completion, late rvalid ignored
        step();
        valid_i  = 1'b1;
        we_i     = 1'b0;
        funct3_i = 3'b010;
        addr_i   = 32'h0000_0300;
        b.we     = 1'b0;
        b.addr   = 32'h0000_0300;
        b.be     = 4'b1111;
        b.chk_wd = 1'b0;
        b.wd     = 32'h0;
        bq.push_back(b);
        step();
        valid_i   = 1'b0;
        mem_gnt_i = 1'b1;
        step();
        mem_gnt_i = 1'b0;
        step();
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        step();
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 32'h0000_0055;
        step();
        mem_rvalid_i = 1'b0;
        mem_rdata_i  = 32'h0;
        repeat (3) step();

        // Normal operation resumes after the abort
        run_op(0, 3'b100, 32'h0000_0103, 32'h0,        0,  0, 0, 32'hA5000000, 0,  1, 32'h000000A5, 3,   1, 4'b1000, 0, 32'h0);

        step();
        end_req = 1'b1;
        repeat (3) step();
    end

    // Guard against a stalled run
    initial begin
        #200000;
        $display("FAIL watchdog: got no completion by time limit, want summary");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_lsu
`default_nettype wire
